vend_credit_ctrl: RTL and testbench

Credit/change controller for the vending dispenser FSM.
- Accumulates inserted coins into the credit value that drives the dispenser's 8-bit coins input.
- Deducts the selected item's price when the dispenser pulses subtract.
- Returns change as greedy quarter/dime/nickel pulses, either after the dispenser's done pulse or on a coin-return request.
- Sits between the coin acceptor/return mechanism and the dispenser.

---
 rtl/vend_pkg.sv | 42 ++++
 rtl/vend_credit_ctrl_if.sv | 33 +++
 rtl/vend_change_gen.sv | 26 ++
 rtl/vend_credit_ctrl.sv | 138 +++++++++++++
 tb/tb_vend_credit_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared constants, state encoding and price selection for the vending credit controller.
package vend_pkg;

  localparam logic [7:0] COIN_NICKEL  = 8'd5;
  localparam logic [7:0] COIN_DIME    = 8'd10;
  localparam logic [7:0] COIN_QUARTER = 8'd25;

  localparam int unsigned DEF_MAX_CREDIT    = 200;
  localparam int unsigned DEF_PRICE_GUM     = 50;
  localparam int unsigned DEF_PRICE_CANDY   = 75;
  localparam int unsigned DEF_PRICE_COOKIES = 65;
  localparam int unsigned DEF_PRICE_CHIPS   = 85;
  localparam int unsigned DEF_CHANGE_GAP    = 2;

  // Bit positions of the change coin-select one-hot.
  localparam int unsigned SEL_NICKEL  = 0;
  localparam int unsigned SEL_DIME    = 1;
  localparam int unsigned SEL_QUARTER = 2;

  typedef enum logic [1:0] {
    StCredit = 2'd0,
    StChange = 2'd1,
    StGap    = 2'd2
  } state_e;

  // sel = {chips, cookies, candy, gum}; gum wins, and the held price survives an idle select.
  function automatic logic [7:0] item_price(input logic [3:0] sel,
                                            input logic [7:0] p_gum,
                                            input logic [7:0] p_candy,
                                            input logic [7:0] p_cookies,
                                            input logic [7:0] p_chips,
                                            input logic [7:0] held);
    logic [7:0] price;
    if (sel[0])      price = p_gum;
    else if (sel[1]) price = p_candy;
    else if (sel[2]) price = p_cookies;
    else if (sel[3]) price = p_chips;
    else             price = held;
    return price;
  endfunction

endpackage

// File: rtl/vend_credit_ctrl_if.sv
// Coin acceptor / dispenser / change-ejector signals around the credit controller.
interface vend_credit_ctrl_if;
  logic       nickel;
  logic       dime;
  logic       quarter;
  logic       coin_return;
  logic       gum_dispence;
  logic       candy_dispence;
  logic       cookies_dispence;
  logic       chips_dispence;
  logic       subtract;
  logic       done;
  logic [7:0] coins;
  logic       coin_reject;
  logic       ret_quarter;
  logic       ret_dime;
  logic       ret_nickel;
  logic       busy;

  modport master (
    output nickel, dime, quarter, coin_return,
    output gum_dispence, candy_dispence, cookies_dispence, chips_dispence,
    output subtract, done,
    input  coins, coin_reject, ret_quarter, ret_dime, ret_nickel, busy
  );

  modport slave (
    input  nickel, dime, quarter, coin_return,
    input  gum_dispence, candy_dispence, cookies_dispence, chips_dispence,
    input  subtract, done,
    output coins, coin_reject, ret_quarter, ret_dime, ret_nickel, busy
  );
endinterface

// File: rtl/vend_change_gen.sv
// Greedy change selector: picks the largest coin that fits and returns the reduced credit.
module vend_change_gen
  import vend_pkg::*;
(
  input  logic [7:0] i_credit,
  output logic [2:0] o_sel,
  output logic [7:0] o_credit
);

  always_comb begin
    o_sel    = 3'b000;
    o_credit = 8'd0;
    if (i_credit >= COIN_QUARTER) begin
      o_sel[SEL_QUARTER] = 1'b1;
      o_credit           = i_credit - COIN_QUARTER;
    end else if (i_credit >= COIN_DIME) begin
      o_sel[SEL_DIME] = 1'b1;
      o_credit        = i_credit - COIN_DIME;
    end else if (i_credit >= COIN_NICKEL) begin
      o_sel[SEL_NICKEL] = 1'b1;
      o_credit          = i_credit - COIN_NICKEL;
    end
    // A 1..4c remainder is dropped with no pulse.
  end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Credit accumulator, price deduction and paced greedy change return for the vending dispenser.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned MAX_CREDIT    = DEF_MAX_CREDIT,
  parameter int unsigned PRICE_GUM     = DEF_PRICE_GUM,
  parameter int unsigned PRICE_CANDY   = DEF_PRICE_CANDY,
  parameter int unsigned PRICE_COOKIES = DEF_PRICE_COOKIES,
  parameter int unsigned PRICE_CHIPS   = DEF_PRICE_CHIPS,
  parameter int unsigned CHANGE_GAP    = DEF_CHANGE_GAP
) (
  input logic               clk,
  input logic               reset,
  vend_credit_ctrl_if.slave bus
);

  localparam int unsigned GapW = (CHANGE_GAP > 1) ? $clog2(CHANGE_GAP) : 1;

  state_e          r_state;
  logic [7:0]      r_coins;
  logic [7:0]      r_price;
  logic [GapW-1:0] r_gap_cnt;
  logic            r_reject;
  logic [2:0]      r_ret;
  logic            r_busy;

  state_e          w_state_nxt;
  logic [7:0]      w_coins_nxt;
  logic [7:0]      w_price_nxt;
  logic [GapW-1:0] w_gap_nxt;
  logic            w_reject_nxt;
  logic [2:0]      w_ret_nxt;
  logic            w_busy_nxt;

  logic [8:0]      w_sum;
  logic [8:0]      w_deduct;
  logic [8:0]      w_base;
  logic [8:0]      w_total;
  logic            w_coin_in;
  logic [2:0]      w_chg_sel;
  logic [7:0]      w_chg_credit;

  vend_change_gen u_change_gen (
    .i_credit (r_coins),
    .o_sel    (w_chg_sel),
    .o_credit (w_chg_credit)
  );

  always_comb begin
    w_price_nxt = item_price({bus.chips_dispence, bus.cookies_dispence,
                              bus.candy_dispence, bus.gum_dispence},
                             8'(PRICE_GUM), 8'(PRICE_CANDY), 8'(PRICE_COOKIES),
                             8'(PRICE_CHIPS), r_price);
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_coins_nxt  = r_coins;
    w_gap_nxt    = r_gap_cnt;
    w_reject_nxt = 1'b0;
    w_ret_nxt    = 3'b000;
    w_coin_in    = bus.nickel | bus.dime | bus.quarter;
    w_sum        = (bus.nickel  ? {1'b0, COIN_NICKEL}  : 9'd0)
                 + (bus.dime    ? {1'b0, COIN_DIME}    : 9'd0)
                 + (bus.quarter ? {1'b0, COIN_QUARTER} : 9'd0);
    w_deduct     = bus.subtract ? {1'b0, r_price} : 9'd0;
    // Deduction saturates so an underpaid subtract clears credit instead of wrapping.
    w_base       = ({1'b0, r_coins} >= w_deduct) ? ({1'b0, r_coins} - w_deduct) : 9'd0;
    w_total      = w_base + w_sum;

    unique case (r_state)
      StCredit: begin
        if (w_total > 9'(MAX_CREDIT)) begin
          w_coins_nxt  = w_base[7:0];
          w_reject_nxt = 1'b1;
        end else begin
          w_coins_nxt = w_total[7:0];
        end
        if ((bus.done || bus.coin_return) && (w_coins_nxt != 8'd0)) begin
          w_state_nxt = StChange;
        end
      end
      StChange: begin
        w_reject_nxt = w_coin_in;
        w_ret_nxt    = w_chg_sel;
        w_coins_nxt  = w_chg_credit;
        if (w_chg_credit != 8'd0) begin
          w_state_nxt = StGap;
          w_gap_nxt   = GapW'(CHANGE_GAP - 1);
        end else begin
          w_state_nxt = StCredit;
        end
      end
      StGap: begin
        w_reject_nxt = w_coin_in;
        if (r_gap_cnt == '0) begin
          w_state_nxt = StChange;
        end else begin
          w_gap_nxt = r_gap_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = StCredit;
      end
    endcase

    // Busy also covers the cycle in which the final change pulse is visible.
    w_busy_nxt = (w_state_nxt != StCredit) || (r_state == StChange);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StCredit;
      r_coins   <= 8'd0;
      r_price   <= 8'd0;
      r_gap_cnt <= '0;
      r_reject  <= 1'b0;
      r_ret     <= 3'b000;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_coins   <= w_coins_nxt;
      r_price   <= w_price_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_reject  <= w_reject_nxt;
      r_ret     <= w_ret_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign bus.coins       = r_coins;
  assign bus.coin_reject = r_reject;
  assign bus.ret_quarter = r_ret[SEL_QUARTER];
  assign bus.ret_dime    = r_ret[SEL_DIME];
  assign bus.ret_nickel  = r_ret[SEL_NICKEL];
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed bench for vend_credit_ctrl with hand-computed expected credit and pulse values.
module tb_vend_credit_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  vend_credit_ctrl_if bus ();

  vend_credit_ctrl #(
    .MAX_CREDIT    (200),
    .PRICE_GUM     (50),
    .PRICE_CANDY   (75),
    .PRICE_COOKIES (65),
    .PRICE_CHIPS   (85),
    .CHANGE_GAP    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ret = {quarter, dime, nickel}
  task automatic chk_all(input string tag, input int coins, input logic rej,
                         input logic [2:0] ret, input logic busy);
    chk({tag, ".coins"}, 16'(bus.coins), 16'(coins));
    chk({tag, ".reject"}, 16'(bus.coin_reject), 16'(rej));
    chk({tag, ".ret"}, 16'({bus.ret_quarter, bus.ret_dime, bus.ret_nickel}), 16'(ret));
    chk({tag, ".busy"}, 16'(bus.busy), 16'(busy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of strobes: {nickel, dime, quarter, coin_return, subtract, done}
  task automatic drive(input logic [5:0] s);
    {bus.nickel, bus.dime, bus.quarter, bus.coin_return, bus.subtract, bus.done} = s;
    tick();
    {bus.nickel, bus.dime, bus.quarter, bus.coin_return, bus.subtract, bus.done} = 6'b0;
  endtask

  localparam logic [5:0] N = 6'b100000, D = 6'b010000, Q = 6'b001000;
  localparam logic [5:0] CR = 6'b000100, SUB = 6'b000010, DN = 6'b000001;

  initial begin
    reset = 1'b1;
    {bus.nickel, bus.dime, bus.quarter, bus.coin_return, bus.subtract, bus.done} = 6'b0;
    {bus.gum_dispence, bus.candy_dispence, bus.cookies_dispence, bus.chips_dispence} = 4'b0;
    #12;
    chk_all("reset", 0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // 1: two quarters, gum, subtract, done with zero credit
    drive(Q);
    chk("t1.q1", 16'(bus.coins), 16'd25);
    drive(Q);
    chk("t1.q2", 16'(bus.coins), 16'd50);
    bus.gum_dispence = 1'b1;
    tick();
    drive(SUB);
    bus.gum_dispence = 1'b0;
    chk("t1.sub", 16'(bus.coins), 16'd0);
    drive(DN);
    chk_all("t1.done", 0, 1'b0, 3'b000, 1'b0);
    tick();
    chk_all("t1.after", 0, 1'b0, 3'b000, 1'b0);

    // 2: 100c, candy, one quarter of change
    repeat (4) drive(Q);
    chk("t2.credit", 16'(bus.coins), 16'd100);
    bus.candy_dispence = 1'b1;
    tick();
    drive(SUB);
    bus.candy_dispence = 1'b0;
    chk("t2.sub", 16'(bus.coins), 16'd25);
    drive(DN);
    chk_all("t2.change", 25, 1'b0, 3'b000, 1'b1);
    tick();
    chk_all("t2.retq", 0, 1'b0, 3'b100, 1'b1);
    tick();
    chk_all("t2.idle", 0, 1'b0, 3'b000, 1'b0);

    // 3: 40c refund paced by the gap
    drive(N | D | Q);
    chk_all("t3.credit", 40, 1'b0, 3'b000, 1'b0);
    drive(CR);
    chk_all("t3.change", 40, 1'b0, 3'b000, 1'b1);
    tick();
    chk_all("t3.retq", 15, 1'b0, 3'b100, 1'b1);
    tick();
    chk_all("t3.gap1", 15, 1'b0, 3'b000, 1'b1);
    tick();
    chk_all("t3.gap2", 15, 1'b0, 3'b000, 1'b1);
    tick();
    chk_all("t3.retd", 5, 1'b0, 3'b010, 1'b1);
    tick();
    tick();
    chk_all("t3.gap4", 5, 1'b0, 3'b000, 1'b1);
    tick();
    chk_all("t3.retn", 0, 1'b0, 3'b001, 1'b1);
    tick();
    chk_all("t3.done", 0, 1'b0, 3'b000, 1'b0);

    // 4: ceiling rejection
    repeat (7) drive(Q);
    drive(N | D);
    chk_all("t4.credit", 190, 1'b0, 3'b000, 1'b0);
    drive(Q);
    chk_all("t4.rejq", 190, 1'b1, 3'b000, 1'b0);
    tick();
    chk("t4.rejclr", 16'(bus.coin_reject), 16'd0);
    drive(N | D);
    chk_all("t4.rejnd", 190, 1'b1, 3'b000, 1'b0);
    drive(N);
    chk_all("t4.nickel", 195, 1'b0, 3'b000, 1'b0);

    // asynchronous clear between scenarios
    #1 reset = 1'b1;
    #2 chk_all("t4.reset", 0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // 5: subtract with a coin, then a coin during GAP
    repeat (3) drive(Q);
    drive(D);
    chk("t5.credit", 16'(bus.coins), 16'd85);
    bus.chips_dispence = 1'b1;
    tick();
    drive(SUB | D);
    bus.chips_dispence = 1'b0;
    chk_all("t5.subdime", 10, 1'b0, 3'b000, 1'b0);
    drive(Q);
    chk("t5.c35", 16'(bus.coins), 16'd35);
    drive(CR);
    tick();
    chk_all("t5.retq", 10, 1'b0, 3'b100, 1'b1);
    drive(D);
    chk_all("t5.gaprej", 10, 1'b1, 3'b000, 1'b1);
    tick();
    chk_all("t5.gap", 10, 1'b0, 3'b000, 1'b1);
    tick();
    chk_all("t5.retd", 0, 1'b0, 3'b010, 1'b1);
    tick();
    chk_all("t5.idle", 0, 1'b0, 3'b000, 1'b0);

    // price priority and saturating deduction
    repeat (3) drive(Q);
    bus.candy_dispence   = 1'b1;
    bus.cookies_dispence = 1'b1;
    tick();
    drive(SUB);
    {bus.candy_dispence, bus.cookies_dispence} = 2'b00;
    chk("t7.prio", 16'(bus.coins), 16'd0);
    drive(Q);
    bus.gum_dispence   = 1'b1;
    bus.chips_dispence = 1'b1;
    tick();
    {bus.gum_dispence, bus.chips_dispence} = 2'b00;
    drive(SUB);
    chk_all("t7.sat", 0, 1'b0, 3'b000, 1'b0);
    drive(CR);
    chk_all("t7.cr0", 0, 1'b0, 3'b000, 1'b0);

    // 6: reset in the middle of a refund
    repeat (4) drive(Q);
    drive(CR);
    tick();
    chk_all("t6.retq", 75, 1'b0, 3'b100, 1'b1);
    #1 reset = 1'b1;
    #1 chk_all("t6.abort", 0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) tick();
    chk_all("t6.quiet", 0, 1'b0, 3'b000, 1'b0);
    drive(N);
    chk_all("t6.credit", 5, 1'b0, 3'b000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
